tych_arb: RTL and testbench
===========================

# tych_arb

Packet-atomic round-robin arbiter that merges `NUM_PORTS` `core_avl_t` input streams onto one `core_avl_t` output stream. It sits upstream of a shared core datapath stage, such as a single-lane `tych_fwd` consumer. Once a port wins arbitration it keeps the output until its `eop` beat transfers. The output is registered, so latency is one cycle and throughput is one beat per cycle.

## Interface
- `NUM_PORTS`, default 2: number of requesting input streams. Legal range is 2..8.
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `core_avl_in`  in  `core_avl_t [NUM_PORTS-1:0]`: requester streams, with fields `valid`, `data`, `sop`, `eop`, `empty`, `error`, `frm_dbg_id`.
- `core_avl_in_ready`  out  `[NUM_PORTS-1:0]`: per-port accept. A beat transfers when `valid && ready` in the same cycle (ready latency 0).
- `core_avl_out`  out  `core_avl_t`: merged stream, registered.
- `core_avl_out_ready`  in  1: downstream accept. A beat transfers when `core_avl_out.valid && core_avl_out_ready`.
- `arb_owner`  out  `$clog2(NUM_PORTS)`: index of the port currently holding the lock. Valid while `arb_locked` is 1.
- `arb_locked`  out  1: high from acceptance of a multi-beat `sop` beat until acceptance of its `eop` beat.
- `pkt_cnt`  out  `[NUM_PORTS-1:0][15:0]`: per-port count of completed packets. Present only with `TYCH_ARB_PKT_CNT_EN`.

## Operation
- Output slot:
  - `load_en = !core_avl_out.valid || core_avl_out_ready`.
  - A beat accepted from any input is written into the output register on the same edge, with all fields copied unchanged.
  - If `load_en` is high and no beat is accepted, `core_avl_out.valid` goes to 0.
- States:
  - **IDLE**
    - Candidates are ports with `valid && sop`.
    - The winner is the first candidate scanning upward from `rr_ptr`, wrapping modulo `NUM_PORTS`.
    - When `load_en` is high, `core_avl_in_ready[winner]=1` and the beat is accepted.
    - `rr_ptr` becomes `(winner+1) % NUM_PORTS`.
    - If the accepted beat has `eop=0`, go to LOCKED with `arb_owner=winner`. A single-beat packet (`sop=eop=1`) stays in IDLE.
  - **LOCKED**
    - `core_avl_in_ready[arb_owner] = load_en`. All other ports see ready 0.
    - Acceptance of an `eop` beat from the owner returns the block to IDLE.
    - A `sop` beat from the owner while locked is forwarded unchanged and the lock is retained.
- Stray beats: in IDLE, any port presenting `valid && !sop` gets ready=1 and the beat is discarded (flushed). The output is not written. This happens regardless of `load_en` and in the same cycle as a grant to another port.
- Owner bubbles: in LOCKED, if the owner's `valid` is 0, the output drains and no other port is granted.
- `rr_ptr` advances only on `sop` acceptance. It never advances on an empty cycle.

## Timing
- Reset values: `core_avl_out` all fields 0, `core_avl_in_ready` all 0, `arb_locked`=0, `arb_owner`=0, `rr_ptr`=0, state IDLE, `pkt_cnt` all 0.
- Latency: an input beat accepted at edge N appears on `core_avl_out` after edge N, and holds until transferred.
- Backpressure: the output register holds when `valid && !core_avl_out_ready`.
- `core_avl_in_ready` is combinational from `state`, `rr_ptr`, the input `valid`/`sop` fields, `core_avl_out.valid` and `core_avl_out_ready`. There is no combinational path from `data`.
- The IDLE-to-grant decision and the beat transfer happen in the same cycle. There is no arbitration bubble.
- Back-to-back packets: `eop` accepted at edge N, then the next `sop` (any port) can be accepted at edge N+1. The sustained rate is 1 beat per cycle.
- Reset mid-packet: the packet is truncated. No `eop` is emitted; the downstream handles truncation via its own reset.

## Configuration
- `TYCH_ARB_PKT_CNT_EN` defined:
  - Instantiates the `pkt_cnt` port.
  - Each port has a 16-bit counter that increments by 1 when an `eop` beat from that port is accepted.
  - Counters wrap from 0xFFFF to 0x0000.
  - Flushed stray beats are not counted.
- Not defined: the `pkt_cnt` port and counters are absent, and all other behaviour is identical.

## Test plan
- Single port, 3-beat packet on port 0, `out_ready`=1:
  - Output shows the beats one cycle later with identical `data`/`frm_dbg_id`.
  - `arb_locked` is 1 for exactly 2 cycles.
  - `pkt_cnt[0]`=1.
- Both ports hold 4-beat packets from reset:
  - Port 0 wins (`rr_ptr`=0); port 1's 4 beats follow with no gap.
  - The next round starts at port 0 again. There is no interleaving within a packet.
- Backpressure: hold `out_ready`=0 for 5 cycles mid-packet.
  - The output beat stays stable and all input readies are 0.
  - After release, beats resume in order with none lost or duplicated.
- Stray beat: port 1 presents `valid=1, sop=0` while idle, and port 0 presents `sop=eop=1` in the same cycle.
  - Port 1's beat is flushed and port 0's beat is forwarded.
  - `pkt_cnt[1]` is unchanged.
- Assert `rst` on the 2nd beat of a 4-beat packet:
  - The next cycle shows all outputs at reset values.
  - A new `sop` on port 1 is then granted immediately.
- With the macro defined, send 65537 single-beat packets on port 0 → `pkt_cnt[0]`=1.

Source files
------------

// File: rtl/tych_arb.sv
// Packet-atomic round-robin arbiter merging NUM_PORTS core_avl_t streams onto one registered output.
// Optional per-port completed-packet counters are enabled with `define TYCH_ARB_PKT_CNT_EN.
//
// state  | meaning
// IDLE   | no packet open; grant the first sop candidate at/after rr_ptr, flush stray beats
// LOCKED | a multi-beat packet is open; only arb_owner may transfer until its eop beat

package tych_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
        logic        error;
        logic [7:0]  frm_dbg_id;
    } core_avl_t;
endpackage

module tych_arb
    import tych_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    localparam int PW = $clog2(NUM_PORTS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  core_avl_t [NUM_PORTS-1:0] core_avl_in,
    output logic      [NUM_PORTS-1:0] core_avl_in_ready,
    output core_avl_t                 core_avl_out,
    input  logic                      core_avl_out_ready,
    output logic      [PW-1:0]        arb_owner,
    output logic                      arb_locked
`ifdef TYCH_ARB_PKT_CNT_EN
    ,
    output logic [NUM_PORTS-1:0][15:0] pkt_cnt
`endif
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t    state_q, state_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    core_avl_t out_q, out_d;

    logic          load_en;
    logic          found;
    logic [PW-1:0] winner;
    logic          take;
    logic [PW-1:0] sel;

    // Descending scan so the candidate closest to rr_ptr is written last and wins.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % NUM_PORTS;
            if (core_avl_in[idx].valid && core_avl_in[idx].sop) begin
                found  = 1'b1;
                winner = PW'(idx);
            end
        end
    end

    always_comb begin
        load_en           = !out_q.valid || core_avl_out_ready;
        core_avl_in_ready = '0;
        state_d           = state_q;
        owner_d           = owner_q;
        rr_ptr_d          = rr_ptr_q;
        take              = 1'b0;
        sel               = '0;
        out_d             = out_q;

        case (state_q)
            IDLE: begin
                // Stray mid-packet beats are drained even while the output is stalled.
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (core_avl_in[i].valid && !core_avl_in[i].sop) begin
                        core_avl_in_ready[i] = 1'b1;
                    end
                end
                if (found && load_en) begin
                    core_avl_in_ready[winner] = 1'b1;
                    take     = 1'b1;
                    sel      = winner;
                    rr_ptr_d = PW'((int'(winner) + 1) % NUM_PORTS);
                    if (!core_avl_in[winner].eop) begin
                        state_d = LOCKED;
                        owner_d = winner;
                    end
                end
            end
            LOCKED: begin
                core_avl_in_ready[owner_q] = load_en;
                if (load_en && core_avl_in[owner_q].valid) begin
                    take = 1'b1;
                    sel  = owner_q;
                    if (core_avl_in[owner_q].eop) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            out_d = core_avl_in[sel];
        end else if (load_en) begin
            out_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            out_q    <= out_d;
        end
    end

    assign core_avl_out = out_q;
    assign arb_owner    = owner_q;
    assign arb_locked   = (state_q == LOCKED);

`ifdef TYCH_ARB_PKT_CNT_EN
    logic [NUM_PORTS-1:0][15:0] pkt_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q <= '0;
        end else if (take && core_avl_in[sel].eop) begin
            pkt_cnt_q[sel] <= pkt_cnt_q[sel] + 16'd1;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_tych_arb.sv
// Self-checking bench for tych_arb: directed vector table, reset/wrap sequences, and random
// traffic checked cycle by cycle against a behavioural arbitration model.
module tb_tych_arb;
    import tych_pkg::*;

    localparam int N = 2;

    logic              clk = 1'b0;
    logic              rst;
    core_avl_t [N-1:0] av_in;
    logic      [N-1:0] rdy;
    core_avl_t         av_out;
    logic              ordy;
    logic      [0:0]   owner;
    logic              locked;
`ifdef TYCH_ARB_PKT_CNT_EN
    logic [N-1:0][15:0] cnt;
`endif

    tych_arb #(.NUM_PORTS(N)) dut (
        .clk                (clk),
        .rst                (rst),
        .core_avl_in        (av_in),
        .core_avl_in_ready  (rdy),
        .core_avl_out       (av_out),
        .core_avl_out_ready (ordy),
        .arb_owner          (owner),
        .arb_locked         (locked)
`ifdef TYCH_ARB_PKT_CNT_EN
        ,
        .pkt_cnt            (cnt)
`endif
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic core_avl_t mk(input logic [2:0] vse, input logic [31:0] d);
        core_avl_t b;
        b            = '0;
        b.valid      = vse[2];
        b.sop        = vse[1];
        b.eop        = vse[0];
        b.data       = d;
        b.frm_dbg_id = d[7:0];
        return b;
    endfunction

    typedef struct {
        logic [2:0]  p0;
        logic [31:0] d0;
        logic [2:0]  p1;
        logic [31:0] d1;
        logic        ordy;
        logic [1:0]  rdy;
        logic        ov;
        logic [31:0] od;
        logic        lock;
        logic        own;
    } vec_t;

    vec_t tbl[14];

    // Behavioural model state
    core_avl_t m_out;
    bit        m_lock;
    int        m_own;
    int        m_rr;
    int        m_cnt[N];

    task automatic model_reset();
        m_out  = '0;
        m_lock = 0;
        m_own  = 0;
        m_rr   = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        av_in = '0;
        ordy  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [N-1:0] e_rdy;
        logic         load;
        int           w;
        bit           acc;
        core_avl_t    beat;

        tbl[0]  = '{3'b110, 32'hA0, 3'b000, 32'h0,  1, 2'b01, 1, 32'hA0, 1, 0};
        tbl[1]  = '{3'b100, 32'hA1, 3'b110, 32'hB0, 1, 2'b01, 1, 32'hA1, 1, 0};
        tbl[2]  = '{3'b101, 32'hA2, 3'b110, 32'hB0, 1, 2'b01, 1, 32'hA2, 0, 0};
        tbl[3]  = '{3'b111, 32'hC0, 3'b110, 32'hB0, 1, 2'b10, 1, 32'hB0, 1, 1};
        tbl[4]  = '{3'b111, 32'hC0, 3'b101, 32'hB1, 1, 2'b10, 1, 32'hB1, 0, 0};
        tbl[5]  = '{3'b111, 32'hC0, 3'b000, 32'h0,  1, 2'b01, 1, 32'hC0, 0, 0};
        tbl[6]  = '{3'b000, 32'h0,  3'b101, 32'h5F, 1, 2'b10, 0, 32'h0,  0, 0};
        tbl[7]  = '{3'b111, 32'hD0, 3'b100, 32'h5E, 1, 2'b11, 1, 32'hD0, 0, 0};
        tbl[8]  = '{3'b110, 32'hE0, 3'b000, 32'h0,  0, 2'b00, 1, 32'hD0, 0, 0};
        tbl[9]  = '{3'b110, 32'hE0, 3'b100, 32'h5D, 0, 2'b10, 1, 32'hD0, 0, 0};
        tbl[10] = '{3'b110, 32'hE0, 3'b000, 32'h0,  1, 2'b01, 1, 32'hE0, 1, 0};
        tbl[11] = '{3'b101, 32'hE1, 3'b000, 32'h0,  0, 2'b00, 1, 32'hE0, 1, 0};
        tbl[12] = '{3'b101, 32'hE1, 3'b000, 32'h0,  1, 2'b01, 1, 32'hE1, 0, 0};
        tbl[13] = '{3'b000, 32'h0,  3'b000, 32'h0,  1, 2'b00, 0, 32'h0,  0, 0};

        rst   = 1'b1;
        av_in = '0;
        ordy  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", 64'(av_out), 64'h0);
        chk("reset_lock", 64'(locked), 64'h0);
        chk("reset_owner", 64'(owner), 64'h0);
        chk("reset_ready", 64'(rdy), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            av_in[0] = mk(tbl[i].p0, tbl[i].d0);
            av_in[1] = mk(tbl[i].p1, tbl[i].d1);
            ordy     = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_ready", i), 64'(rdy), 64'(tbl[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_ovalid", i), 64'(av_out.valid), 64'(tbl[i].ov));
            if (tbl[i].ov) begin
                chk($sformatf("tbl%0d_data", i), 64'(av_out.data), 64'(tbl[i].od));
                chk($sformatf("tbl%0d_dbg", i), 64'(av_out.frm_dbg_id), 64'(tbl[i].od[7:0]));
            end
            chk($sformatf("tbl%0d_lock", i), 64'(locked), 64'(tbl[i].lock));
            if (tbl[i].lock) chk($sformatf("tbl%0d_owner", i), 64'(owner), 64'(tbl[i].own));
        end
`ifdef TYCH_ARB_PKT_CNT_EN
        chk("tbl_cnt0", 64'(cnt[0]), 64'd4);
        chk("tbl_cnt1", 64'(cnt[1]), 64'd1);
`endif

        // Reset in the middle of a 4-beat packet
        do_reset();
        av_in[0] = mk(3'b110, 32'h71);
        @(posedge clk);
        @(negedge clk);
        av_in[0] = mk(3'b100, 32'h72);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        av_in = '0;
        #1;
        chk("midrst_out", 64'(av_out), 64'h0);
        chk("midrst_lock", 64'(locked), 64'h0);
        chk("midrst_owner", 64'(owner), 64'h0);
        chk("midrst_ready", 64'(rdy), 64'h0);
        av_in[1] = mk(3'b110, 32'h81);
        #1;
        chk("midrst_grant1", 64'(rdy), 64'b10);
        @(posedge clk);
        #1;
        chk("midrst_out1", 64'(av_out.data), 64'h81);
        chk("midrst_lock1", 64'(locked), 64'h1);
        chk("midrst_owner1", 64'(owner), 64'h1);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int p = 0; p < N; p++) begin
                av_in[p]            = core_avl_t'({$urandom, $urandom});
                av_in[p].valid      = ($urandom_range(0, 3) != 0);
                av_in[p].sop        = ($urandom_range(0, 3) == 0);
                av_in[p].eop        = ($urandom_range(0, 2) == 0);
            end
            ordy = (c % 97 < 5) ? 1'b0 : ($urandom_range(0, 3) != 0);

            load  = !m_out.valid || ordy;
            e_rdy = '0;
            acc   = 0;
            beat  = '0;
            if (!m_lock) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_rr + k) % N;
                    if (w < 0 && av_in[idx].valid && av_in[idx].sop) w = idx;
                end
                for (int p = 0; p < N; p++) e_rdy[p] = av_in[p].valid && !av_in[p].sop;
                if (w >= 0 && load) begin
                    e_rdy[w] = 1'b1;
                    acc      = 1;
                    beat     = av_in[w];
                    m_rr     = (w + 1) % N;
                    if (!beat.eop) begin
                        m_lock = 1;
                        m_own  = w;
                    end
                end
            end else begin
                w        = m_own;
                e_rdy[w] = load;
                if (load && av_in[w].valid) begin
                    acc  = 1;
                    beat = av_in[w];
                    if (beat.eop) m_lock = 0;
                end
            end
            if (acc && beat.eop) m_cnt[w] = (m_cnt[w] + 1) % 65536;
            if (acc) m_out = beat;
            else if (load) m_out.valid = 1'b0;

            #1;
            chk("rnd_ready", 64'(rdy), 64'(e_rdy));
            @(posedge clk);
            #1;
            if (m_out.valid) chk("rnd_out", 64'(av_out), 64'(m_out));
            else chk("rnd_ovalid", 64'(av_out.valid), 64'h0);
            chk("rnd_lock", 64'(locked), 64'(m_lock));
            if (m_lock) chk("rnd_owner", 64'(owner), 64'(m_own));
`ifdef TYCH_ARB_PKT_CNT_EN
            for (int p = 0; p < N; p++) chk("rnd_cnt", 64'(cnt[p]), 64'(m_cnt[p]));
`endif
            @(negedge clk);
        end

`ifdef TYCH_ARB_PKT_CNT_EN
        // Counter wrap: 65537 single-beat packets leave the count at 1
        do_reset();
        av_in[0] = mk(3'b111, 32'h99);
        ordy     = 1'b1;
        repeat (65537) @(posedge clk);
        #1;
        av_in = '0;
        chk("wrap_cnt0", 64'(cnt[0]), 64'd1);
        chk("wrap_cnt1", 64'(cnt[1]), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
